// File: rtl/pia_host_pkg.sv
// Shared op codes, FSM states and PIA register map for the PIA bus host.
package pia_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_READ     = 2'b01,
    OP_ARM_WAIT = 2'b10,
    OP_NOP      = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    StIdle,
    StWrResp,
    StRdWait,
    StRdCap,
    StArm,
    StGap,
    StPollRd,
    StPollCap,
    StFinRd,
    StFinCap,
    StResp
  } state_e;

  localparam logic [6:0] SWCHA  = 7'h00;
  localparam logic [6:0] SWACNT = 7'h01;
  localparam logic [6:0] SWCHB  = 7'h02;
  localparam logic [6:0] SWBCNT = 7'h03;
  localparam logic [6:0] INTIM  = 7'h04;
  localparam logic [6:0] INSTAT = 7'h05;
  localparam logic [6:0] TIM1T  = 7'h14;
  localparam logic [6:0] TIM8T  = 7'h15;
  localparam logic [6:0] TIM64T = 7'h16;
  localparam logic [6:0] T1024T = 7'h17;

  localparam int unsigned INSTAT_UF_BIT = 7;

  function automatic logic is_timer_adr(input logic [6:0] adr);
    return (adr >= TIM1T) && (adr <= T1024T);
  endfunction

endpackage

// File: rtl/pia_host.sv
// Single-command bus initiator for the PIA: write, read, or arm the timer and poll for underflow.
// Optional PIA_HOST_POLLCNT_EN adds rsp_polls_o (INSTAT reads in the last ARM_WAIT).
module pia_host
  import pia_host_pkg::*;
#(
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned TO_W     = 20
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [6:0]      cmd_adr_i,
  input  logic [7:0]      cmd_dat_i,
  output logic            rsp_valid_o,
  output logic [7:0]      rsp_dat_o,
  output logic            rsp_err_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [6:0]      adr_o,
  output logic [7:0]      dat_o,
  input  logic [7:0]      dat_i
`ifdef PIA_HOST_POLLCNT_EN
  ,
  output logic [15:0]     rsp_polls_o
`endif
);

  localparam logic [7:0] GapLast = 8'(POLL_GAP - 1);

  state_e          r_state;
  logic [7:0]      r_gap;
  logic [TO_W-1:0] r_to;
  logic [7:0]      r_instat;
  logic [7:0]      r_res;
  logic            r_err;
  logic            w_arm_busy;

  assign cmd_ready_o = (r_state == StIdle) && !rst_i;
  assign w_arm_busy  = r_state inside {StArm, StGap, StPollRd, StPollCap, StFinRd, StFinCap};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      r_gap       <= '0;
      r_to        <= '0;
      r_instat    <= '0;
      r_res       <= '0;
      r_err       <= 1'b0;
    end else begin
      stb_o       <= 1'b0;
      rsp_valid_o <= 1'b0;
      if (w_arm_busy && (r_to != '1)) r_to <= r_to + 1'b1;
      unique case (r_state)
        StIdle: if (cmd_valid_i) begin
          r_to     <= '0;
          r_gap    <= '0;
          r_instat <= '0;
          unique case (op_e'(cmd_op_i))
            OP_WRITE: begin
              {stb_o, we_o} <= 2'b11;
              adr_o         <= cmd_adr_i;
              dat_o         <= cmd_dat_i;
              r_state       <= StWrResp;
            end
            OP_READ: begin
              {stb_o, we_o} <= 2'b10;
              adr_o         <= cmd_adr_i;
              r_state       <= StRdWait;
            end
            OP_ARM_WAIT: begin
              if (is_timer_adr(cmd_adr_i)) begin
                {stb_o, we_o} <= 2'b11;
                adr_o         <= cmd_adr_i;
                dat_o         <= cmd_dat_i;
                r_state       <= StArm;
              end else begin
                rsp_valid_o <= 1'b1;
                rsp_dat_o   <= '0;
                rsp_err_o   <= 1'b1;
              end
            end
            OP_NOP: begin
              rsp_valid_o <= 1'b1;
              rsp_dat_o   <= '0;
              rsp_err_o   <= 1'b0;
            end
          endcase
        end
        StWrResp: begin
          rsp_valid_o <= 1'b1;
          rsp_dat_o   <= '0;
          rsp_err_o   <= 1'b0;
          r_state     <= StIdle;
        end
        StRdWait: r_state <= StRdCap;
        StRdCap: begin
          rsp_valid_o <= 1'b1;
          rsp_dat_o   <= dat_i;
          rsp_err_o   <= 1'b0;
          r_state     <= StIdle;
        end
        StArm: r_state <= StGap;
        // Timeout only aborts between polls so an issued read always completes.
        StGap: begin
          if (r_to == '1) begin
            r_res   <= r_instat;
            r_err   <= 1'b1;
            r_state <= StResp;
          end else if (r_gap == GapLast) begin
            {stb_o, we_o} <= 2'b10;
            adr_o         <= INSTAT;
            r_state       <= StPollRd;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        StPollRd: r_state <= StPollCap;
        StPollCap: begin
          r_instat <= dat_i;
          r_gap    <= '0;
          if (dat_i[INSTAT_UF_BIT]) begin
            {stb_o, we_o} <= 2'b10;
            adr_o         <= INTIM;
            r_state       <= StFinRd;
          end else begin
            r_state <= StGap;
          end
        end
        StFinRd: r_state <= StFinCap;
        StFinCap: begin
          r_res   <= dat_i;
          r_err   <= 1'b0;
          r_state <= StResp;
        end
        StResp: begin
          rsp_valid_o <= 1'b1;
          rsp_dat_o   <= r_res;
          rsp_err_o   <= r_err;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef PIA_HOST_POLLCNT_EN
  logic [15:0] r_polls;

  // Poll count is published only alongside an ARM_WAIT response; zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_polls     <= '0;
      rsp_polls_o <= '0;
    end else begin
      if (cmd_ready_o && cmd_valid_i) r_polls <= '0;
      else if ((r_state == StPollCap) && (r_polls != '1)) r_polls <= r_polls + 1'b1;
      rsp_polls_o <= (r_state == StResp) ? r_polls : '0;
    end
  end
`endif

endmodule
